aes_uart_ctrl: RTL and testbench
================================

Name: aes_uart_ctrl

Overview:
Command sequencer between the UART byte link and the AES core.
- Parses host command frames from the UART receiver.
- Holds the 128-bit key.
- Launches the AES core for encryption or decryption and waits for its done flag.
- Streams the 16-byte result back through the UART transmitter.
- Sits at top level: UART RX/TX on one side, AES core start/done handshake on the other.

Parameters:
RX_TIMEOUT, 1_000_000, idle cycles allowed between bytes inside a frame before abort
AES_TIMEOUT, 4096, max cycles from AES start to done before abort

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  asynchronous active-low reset
i_RxValid  input  1  one-cycle pulse: i_RxByte valid
i_RxByte  input  8  received byte
o_TxStart  output  1  one-cycle pulse: transmit o_TxByte
o_TxByte  output  8  byte to transmit, stable from o_TxStart until i_TxBusy falls
i_TxBusy  input  1  transmitter busy; rises the cycle after o_TxStart
o_AesStart  output  1  one-cycle start pulse to AES core
o_AesDec  output  1  1 = decrypt, 0 = encrypt; stable while AES runs
o_AesKey  output  128  key register
o_AesText  output  128  input block register
i_AesDone  input  1  AES done pulse
i_AesText  input  128  AES result, valid when i_AesDone = 1
o_Busy  output  1  high in every state except IDLE

Behaviour:
- Reset: i_Rst low asynchronously clears all state and outputs to 0, including the key register. State goes to IDLE. Reset mid-frame, mid-AES or mid-TX discards everything; no partial response is sent.
- Frame formats (byte 1 is the command):
  - 'K' (0x4B) + 16 key bytes -> reply ACK 0x06.
  - 'E' (0x45) or 'D' (0x44) + 16 text bytes -> reply 16 result bytes.
  - Any other command byte -> reply NAK 0x15; state stays IDLE after the reply.
- Byte order: the first data byte lands in [127:120] and the last in [7:0]; 8-bit left shift per byte. The result is sent MSB byte first.
- States:
  - IDLE: waits for i_RxValid and decodes the command. K -> RX_KEY; E/D -> RX_TEXT with o_AesDec latched; else -> TX_NAK.
  - RX_KEY / RX_TEXT: a 4-bit byte counter counts 0..15. On the 16th byte: RX_KEY -> TX_ACK; RX_TEXT -> AES_GO. The key register is only updated on frame completion; a shadow shift register is used, so an aborted K frame leaves the old key intact.
  - AES_GO: o_AesStart = 1 for exactly one cycle -> AES_WAIT.
  - AES_WAIT: on i_AesDone, capture i_AesText into the result register -> TX_DATA with index 0. If AES_TIMEOUT cycles elapse with no done -> TX_NAK.
  - TX_DATA: see TX handshake below; after byte 15 completes -> IDLE.
  - TX_ACK / TX_NAK: send a single byte -> IDLE.
- TX handshake:
  - o_TxStart is issued only when i_TxBusy = 0 and no o_TxStart was issued in the previous cycle (covers the 1-cycle busy latency).
  - The next byte is issued after i_TxBusy has been seen high and then low.
- RX timeout: the counter resets on every i_RxValid within RX_KEY/RX_TEXT. Reaching RX_TIMEOUT aborts the frame -> TX_NAK.
- Bytes arriving outside IDLE/RX_* (AES_*, TX_*) are dropped silently; no buffering.
- Simultaneous events:
  - i_RxValid in the same cycle as the RX timeout: the byte wins and the counter clears.
  - i_AesDone in the same cycle as the AES timeout: done wins.
- Latency: o_AesStart asserts 1 cycle after the 16th text byte's i_RxValid. The first o_TxStart asserts 1 cycle after the i_AesDone capture when i_TxBusy = 0.
- Widths: byte counter 4 bits with wrap detected at 15; timeout counters sized $clog2(param+1). Counters saturate and never wrap.

Decomposition:
- Package aes_uart_pkg:
  - command constants CMD_KEY 0x4B, CMD_ENC 0x45, CMD_DEC 0x44, RSP_ACK 0x06, RSP_NAK 0x15;
  - state enumeration (IDLE, RX_KEY, RX_TEXT, AES_GO, AES_WAIT, TX_DATA, TX_ACK, TX_NAK);
  - BLOCK_BYTES = 16.
- One natural sub-module: aes_uart_txseq. It is the byte-serializer owning the TX handshake and the 16-byte index, with inputs load/data128/single-byte mode and a done output. The FSM and the RX shift logic stay in the top.

Test Plan:
- Send K + 2b7e151628aed2a6abf7158809cf4f3c -> single TX byte 0x06; o_AesKey equals the key; o_AesStart never pulses.
- Then send E + 3243f6a8885a308d313198a2e0370734 -> one o_AesStart pulse with o_AesDec = 0 and o_AesText equal to the plaintext; with AES model result 3925841d02dc09fbdc118597196a0b32, TX bytes are 0x39,0x25,…,0x32 in order.
- Send D + 3925841d02dc09fbdc118597196a0b32 -> o_AesDec = 1; TX returns 0x32,0x43,…,0x34. Hold i_TxBusy high 20 cycles per byte and confirm no extra o_TxStart.
- Send 0x5A -> TX 0x15, back to IDLE. Then K + 5 bytes + RX_TIMEOUT-cycle stall -> TX 0x15; key still 2b7e…3c.
- AES model never asserts done -> TX 0x15 after AES_TIMEOUT cycles. Bytes sent during AES_WAIT are ignored.
- Assert i_Rst low during TX_DATA byte 7 -> all outputs 0 asynchronously; no further o_TxStart; key register 0.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: command bytes, FSM states and block size shared by the AES UART controller.
package aes_uart_pkg;
  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h45;
  localparam logic [7:0] CMD_DEC = 8'h44;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam int BLOCK_BYTES = 16;
  typedef enum logic [2:0] {IDLE, RX_KEY, RX_TEXT, AES_GO, AES_WAIT, TX_DATA, TX_ACK, TX_NAK} state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_READY, TX_WAIT_HI, TX_WAIT_LO} tx_phase_t;
endpackage

// File: rtl/aes_uart_txseq.sv
// aes_uart_txseq: serializes a 128-bit block (or its top byte alone) MSB first over the UART TX handshake.
module aes_uart_txseq
  import aes_uart_pkg::*;
(
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         load,
  input  logic         single,
  input  logic [127:0] data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_byte,
  output logic         done
);
  tx_phase_t phase;
  logic [127:0] sh;
  logic [3:0] idx;
  logic single_q, start_q, last;
  assign last = single_q || idx == 4'(BLOCK_BYTES - 1);
  // start_q masks the cycle before the transmitter's busy flag catches up
  assign tx_start = phase == TX_READY && !tx_busy && !start_q;
  assign tx_byte = sh[127:120];
  assign done = phase == TX_WAIT_LO && !tx_busy && last;
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) begin
      phase    <= TX_IDLE;
      sh       <= '0;
      idx      <= '0;
      single_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q <= tx_start;
      if (load) begin
        phase    <= TX_READY;
        sh       <= data;
        idx      <= '0;
        single_q <= single;
      end else if (tx_start)
        phase <= TX_WAIT_HI;
      else if (phase == TX_WAIT_HI && tx_busy)
        phase <= TX_WAIT_LO;
      else if (phase == TX_WAIT_LO && !tx_busy) begin
        phase <= last ? TX_IDLE : TX_READY;
        sh    <= {sh[119:0], 8'h00};
        idx   <= idx + 4'd1;
      end
    end
endmodule

// File: rtl/aes_uart_ctrl.sv
// aes_uart_ctrl: parses UART command frames, holds the key, runs the AES core and streams the reply.
module aes_uart_ctrl
  import aes_uart_pkg::*;
#(
  parameter int RX_TIMEOUT  = 1_000_000,
  parameter int AES_TIMEOUT = 4096
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_RxValid,
  input  logic [7:0]   i_RxByte,
  output logic         o_TxStart,
  output logic [7:0]   o_TxByte,
  input  logic         i_TxBusy,
  output logic         o_AesStart,
  output logic         o_AesDec,
  output logic [127:0] o_AesKey,
  output logic [127:0] o_AesText,
  input  logic         i_AesDone,
  input  logic [127:0] i_AesText,
  output logic         o_Busy
);
  localparam int RW = $clog2(RX_TIMEOUT + 1);
  localparam int AW = $clog2(AES_TIMEOUT + 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [119:0] shadow;
  logic [127:0] shadow_nx;
  logic [RW-1:0] rx_tmr;
  logic [AW-1:0] aes_tmr;
  logic rx_state, rx_last, is_txt, aes_state, tx_load, tx_single, tx_done;
  logic [7:0] rsp;
  assign rx_state  = state == RX_KEY || state == RX_TEXT;
  assign aes_state = state == AES_GO || state == AES_WAIT;
  assign rx_last   = rx_state && i_RxValid && cnt == 4'd15;
  assign is_txt    = i_RxByte == CMD_ENC || i_RxByte == CMD_DEC;
  assign shadow_nx = {shadow, i_RxByte};
  assign o_AesStart = state == AES_GO;
  assign o_Busy     = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:            if (i_RxValid) state_nx = i_RxByte == CMD_KEY ? RX_KEY : is_txt ? RX_TEXT : TX_NAK;
      RX_KEY, RX_TEXT: state_nx = rx_last ? (state == RX_KEY ? TX_ACK : AES_GO)
                                : (!i_RxValid && rx_tmr == RW'(RX_TIMEOUT)) ? TX_NAK : state;
      AES_GO:          state_nx = AES_WAIT;
      AES_WAIT:        state_nx = i_AesDone ? TX_DATA : aes_tmr == AW'(AES_TIMEOUT) ? TX_NAK : AES_WAIT;
      default:         if (tx_done) state_nx = IDLE;
    endcase
  end
  // the serializer is loaded on entry to any transmit state
  assign tx_load   = state_nx != state && (state_nx == TX_DATA || state_nx == TX_ACK || state_nx == TX_NAK);
  assign tx_single = state_nx != TX_DATA;
  assign rsp       = state_nx == TX_ACK ? RSP_ACK : RSP_NAK;
  always_ff @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      rx_tmr    <= '0;
      aes_tmr   <= '0;
      o_AesKey  <= '0;
      o_AesText <= '0;
      o_AesDec  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= rx_state ? cnt + {3'b000, i_RxValid} : 4'd0;
      rx_tmr  <= (!rx_state || i_RxValid) ? '0 : rx_tmr == RW'(RX_TIMEOUT) ? rx_tmr : rx_tmr + RW'(1);
      aes_tmr <= !aes_state ? '0 : aes_tmr == AW'(AES_TIMEOUT) ? aes_tmr : aes_tmr + AW'(1);
      if (rx_state && i_RxValid) shadow <= shadow_nx[119:0];
      if (state == IDLE && i_RxValid && is_txt) o_AesDec <= i_RxByte == CMD_DEC;
      // key only commits on a complete frame so an aborted K frame keeps the old key
      if (rx_last && state == RX_KEY) o_AesKey <= shadow_nx;
      if (rx_last && state == RX_TEXT) o_AesText <= shadow_nx;
    end
  aes_uart_txseq u_txseq (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .load     (tx_load),
    .single   (tx_single),
    .data     (tx_single ? {rsp, 120'h0} : i_AesText),
    .tx_busy  (i_TxBusy),
    .tx_start (o_TxStart),
    .tx_byte  (o_TxByte),
    .done     (tx_done)
  );
endmodule

// File: tb/tb_aes_uart_ctrl.sv
// tb_aes_uart_ctrl: directed scenario tests of the AES UART controller against small UART-TX and AES models.
module tb_aes_uart_ctrl;
  localparam int RXT = 60;
  localparam int AET = 50;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  logic clk = 1'b0, rst_n = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic tx_start, tx_busy, aes_start, aes_dec, aes_done, busy;
  logic [7:0] tx_byte;
  logic [127:0] aes_key, aes_text_o, res, atext;
  logic adec, hang;
  int busy_len, bcnt, extra, acnt, aes_starts;
  int pass_cnt = 0, total = 0;
  logic [7:0] txq[$];
  always #5 clk = ~clk;
  aes_uart_ctrl #(.RX_TIMEOUT(RXT), .AES_TIMEOUT(AET)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_RxValid(rx_valid), .i_RxByte(rx_byte),
    .o_TxStart(tx_start), .o_TxByte(tx_byte), .i_TxBusy(tx_busy),
    .o_AesStart(aes_start), .o_AesDec(aes_dec), .o_AesKey(aes_key), .o_AesText(aes_text_o),
    .i_AesDone(aes_done), .i_AesText(res), .o_Busy(busy)
  );
  // UART transmitter model: busy rises the cycle after a start and stays high busy_len cycles
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_start) begin
      if (tx_busy) extra <= extra + 1;
      txq.push_back(tx_byte);
      tx_busy <= 1'b1;
      bcnt    <= busy_len;
    end else if (bcnt > 1) bcnt <= bcnt - 1;
    else begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end
  // AES core model: done pulses 5 cycles after start unless hang is set
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aes_done <= 1'b0;
      acnt     <= 0;
    end else begin
      aes_done <= 1'b0;
      if (aes_start) begin
        aes_starts <= aes_starts + 1;
        adec  <= aes_dec;
        atext <= aes_text_o;
        acnt  <= hang ? 0 : 5;
      end else if (acnt > 0) begin
        acnt <= acnt - 1;
        if (acnt == 1) aes_done <= 1'b1;
      end
    end
  function automatic logic [127:0] pack();
    logic [127:0] g = '0;
    foreach (txq[i]) g = {g[119:0], txq[i]};
    return g;
  endfunction
  function automatic logic [7:0] first_tx();
    return txq.size() > 0 ? txq[0] : 8'hxx;
  endfunction
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] d);
    send_byte(cmd);
    for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8]);
  endtask
  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy) $display("FAIL %s: o_Busy still 1 after %0d cycles, want 0", name, budget);
    else pass_cnt++;
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    total += 4;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    if (tx_start !== 1'b0) $display("FAIL reset_txstart: got %b want 0", tx_start); else pass_cnt++;
    if (aes_start !== 1'b0) $display("FAIL reset_aesstart: got %b want 0", aes_start); else pass_cnt++;
    if (aes_key !== 128'h0) $display("FAIL reset_key: got %h want 0", aes_key); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_key();
    int s0 = aes_starts;
    txq.delete();
    send_frame(8'h4B, KEY);
    wait_idle(200, "key_idle");
    total += 4;
    if (txq.size() != 1) $display("FAIL key_txcount: got %0d want 1", txq.size()); else pass_cnt++;
    if (first_tx() !== 8'h06) $display("FAIL key_ack: got %h want 06", first_tx()); else pass_cnt++;
    if (aes_key !== KEY) $display("FAIL key_reg: got %h want %h", aes_key, KEY); else pass_cnt++;
    if (aes_starts != s0) $display("FAIL key_nostart: got %0d starts want 0", aes_starts - s0); else pass_cnt++;
  endtask
  task automatic test_encrypt();
    int s0 = aes_starts;
    txq.delete();
    res = CT;
    send_frame(8'h45, PT);
    total += 3;
    if (aes_start !== 1'b1) $display("FAIL enc_start_latency: got %b want 1", aes_start); else pass_cnt++;
    if (aes_dec !== 1'b0) $display("FAIL enc_dec: got %b want 0", aes_dec); else pass_cnt++;
    if (aes_text_o !== PT) $display("FAIL enc_text: got %h want %h", aes_text_o, PT); else pass_cnt++;
    wait_idle(300, "enc_idle");
    total += 4;
    if (aes_starts != s0 + 1) $display("FAIL enc_startcount: got %0d want 1", aes_starts - s0); else pass_cnt++;
    if (atext !== PT) $display("FAIL enc_model_text: got %h want %h", atext, PT); else pass_cnt++;
    if (txq.size() != 16) $display("FAIL enc_txcount: got %0d want 16", txq.size()); else pass_cnt++;
    if (pack() !== CT) $display("FAIL enc_result: got %h want %h", pack(), CT); else pass_cnt++;
  endtask
  task automatic test_decrypt_slow_tx();
    int e0 = extra;
    txq.delete();
    res = PT;
    busy_len = 20;
    send_frame(8'h44, CT);
    total += 2;
    if (aes_dec !== 1'b1) $display("FAIL dec_flag: got %b want 1", aes_dec); else pass_cnt++;
    if (aes_text_o !== CT) $display("FAIL dec_text: got %h want %h", aes_text_o, CT); else pass_cnt++;
    wait_idle(700, "dec_idle");
    total += 4;
    if (adec !== 1'b1) $display("FAIL dec_model_flag: got %b want 1", adec); else pass_cnt++;
    if (txq.size() != 16) $display("FAIL dec_txcount: got %0d want 16", txq.size()); else pass_cnt++;
    if (pack() !== PT) $display("FAIL dec_result: got %h want %h", pack(), PT); else pass_cnt++;
    if (extra != e0) $display("FAIL dec_extra_start: got %0d starts while busy want 0", extra - e0); else pass_cnt++;
    busy_len = 2;
  endtask
  task automatic test_nak();
    txq.delete();
    send_byte(8'h5A);
    wait_idle(50, "nak_idle");
    total += 2;
    if (txq.size() != 1) $display("FAIL nak_txcount: got %0d want 1", txq.size()); else pass_cnt++;
    if (first_tx() !== 8'h15) $display("FAIL nak_byte: got %h want 15", first_tx()); else pass_cnt++;
  endtask
  task automatic test_rx_timeout();
    txq.delete();
    send_byte(8'h4B);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    total++;
    if (busy !== 1'b1) $display("FAIL rxto_busy: got %b want 1", busy); else pass_cnt++;
    wait_idle(RXT + 50, "rxto_idle");
    total += 3;
    if (txq.size() != 1) $display("FAIL rxto_txcount: got %0d want 1", txq.size()); else pass_cnt++;
    if (first_tx() !== 8'h15) $display("FAIL rxto_nak: got %h want 15", first_tx()); else pass_cnt++;
    if (aes_key !== KEY) $display("FAIL rxto_key_kept: got %h want %h", aes_key, KEY); else pass_cnt++;
  endtask
  task automatic test_aes_timeout();
    txq.delete();
    hang = 1'b1;
    send_frame(8'h45, PT);
    for (int i = 0; i < 3; i++) send_byte(8'h4B);
    total += 2;
    if (busy !== 1'b1) $display("FAIL aesto_waiting: got busy %b want 1", busy); else pass_cnt++;
    if (txq.size() != 0) $display("FAIL aesto_early_tx: got %0d bytes want 0", txq.size()); else pass_cnt++;
    wait_idle(AET + 50, "aesto_idle");
    total += 2;
    if (txq.size() != 1) $display("FAIL aesto_txcount: got %0d want 1", txq.size()); else pass_cnt++;
    if (first_tx() !== 8'h15) $display("FAIL aesto_nak: got %h want 15", first_tx()); else pass_cnt++;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL aesto_dropped_bytes: got busy %b want 0", busy); else pass_cnt++;
    hang = 1'b0;
  endtask
  task automatic test_reset_mid_tx();
    int n = 0;
    txq.delete();
    res = CT;
    busy_len = 3;
    send_frame(8'h45, PT);
    while (txq.size() < 8 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (txq.size() != 8) $display("FAIL rst_reach_byte7: got %0d bytes want 8", txq.size()); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total += 6;
    if (tx_start !== 1'b0) $display("FAIL rst_txstart: got %b want 0", tx_start); else pass_cnt++;
    if (tx_byte !== 8'h00) $display("FAIL rst_txbyte: got %h want 00", tx_byte); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    if (aes_key !== 128'h0) $display("FAIL rst_key: got %h want 0", aes_key); else pass_cnt++;
    if (aes_text_o !== 128'h0) $display("FAIL rst_text: got %h want 0", aes_text_o); else pass_cnt++;
    if (aes_dec !== 1'b0) $display("FAIL rst_dec: got %b want 0", aes_dec); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total += 2;
    if (txq.size() != 8) $display("FAIL rst_no_more_tx: got %0d bytes want 8", txq.size()); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_idle_after: got %b want 0", busy); else pass_cnt++;
    busy_len = 2;
  endtask
  initial begin
    busy_len = 2;
    extra = 0;
    aes_starts = 0;
    hang = 1'b0;
    res = '0;
    test_reset();
    test_key();
    test_encrypt();
    test_decrypt_slow_tx();
    test_nak();
    test_rx_timeout();
    test_aes_timeout();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", pass_cnt, total);
    $fatal(1);
  end
endmodule
